// File: rtl/fft_bitrev_reorder.sv
// -----------------------------------------------------------------------------
// fft_bitrev_reorder
//
// Output reorder stage for the radix-2^2 SDF FFT pipeline. The SDF chain emits
// every N-point frame in bit-reversed index order; this block captures each
// frame into one bank of a ping-pong buffer and replays it in natural order
// (bin 0..N-1) from the other bank. This keeps one sample per cycle flowing
// continuously, with no gaps between back-to-back frames.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (dominates all other inputs)
//   enable_in  input sample valid, high for N consecutive cycles per frame
//   in_re      real part of input sample (bit-reversed order)
//   in_im      imaginary part of input sample (bit-reversed order)
//   enable_out output sample valid, high for exactly N cycles per frame
//   out_re     real part of output sample (natural order)
//   out_im     imaginary part of output sample (natural order)
//
// Latency: if the last input sample of a frame is presented in cycle t, then
// bin 0 appears in cycle t+2 and bin N-1 appears in cycle t+N+1.
// -----------------------------------------------------------------------------
module fft_bitrev_reorder #(
    parameter int N     = 64,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_in,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    output logic             enable_out,
    output logic [WIDTH-1:0] out_re,
    output logic [WIDTH-1:0] out_im
);

    localparam int              LOGN = $clog2(N);
    localparam int              DW   = 2 * WIDTH;
    localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } rd_state_t;

    // Reverse the LOGN-bit sample index into its natural-order bin address.
    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] idx);
        logic [LOGN-1:0] rev;
        rev = '0;
        for (int i = 0; i < LOGN; i++) begin
            rev[i] = idx[LOGN-1-i];
        end
        return rev;
    endfunction

    // Both banks live in one array; the bank select is the address MSB.
    logic [DW-1:0]   mem_r [0:2*N-1];

    logic [LOGN-1:0] wr_cnt_r;
    logic            wr_bank_r;
    rd_state_t       rd_state_r;
    logic [LOGN-1:0] rd_cnt_r;
    logic            rd_bank_r;

    logic            frame_done_s;
    logic            rd_active_s;
    logic [LOGN:0]   wr_addr_s;
    logic [LOGN:0]   rd_addr_s;

    // Frame completion strobe, read-state decode and RAM addresses.
    always_comb begin
        frame_done_s = enable_in && (wr_cnt_r == LAST);
        rd_active_s  = (rd_state_r == ST_READ);
        wr_addr_s    = {wr_bank_r, bitrev(wr_cnt_r)};
        rd_addr_s    = {rd_bank_r, rd_cnt_r};
    end

    // Write side: sample counter and bank select. A gap in enable_in drops
    // any partially captured frame without touching the bank select.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_r  <= '0;
            wr_bank_r <= 1'b0;
        end else if (enable_in) begin
            wr_cnt_r <= wr_cnt_r + LOGN'(1);
            if (frame_done_s) begin
                wr_bank_r <= ~wr_bank_r;
            end else begin
                wr_bank_r <= wr_bank_r;
            end
        end else begin
            wr_cnt_r  <= '0;
            wr_bank_r <= wr_bank_r;
        end
    end

    // RAM write port; storage contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (!rst && enable_in) begin
            mem_r[wr_addr_s] <= {in_re, in_im};
        end
    end

    // Read FSM with the registered outputs. The synchronous RAM read register
    // doubles as the output register, which gives the two-cycle latency.
    // A frame completion on the final read address restarts the read on the
    // freshly filled bank so back-to-back frames stream without a gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_r <= ST_IDLE;
            rd_cnt_r   <= '0;
            rd_bank_r  <= 1'b0;
            enable_out <= 1'b0;
            out_re     <= '0;
            out_im     <= '0;
        end else begin
            enable_out <= rd_active_s;
            if (rd_active_s) begin
                {out_re, out_im} <= mem_r[rd_addr_s];
            end

            if (frame_done_s) begin
                rd_state_r <= ST_READ;
                rd_cnt_r   <= '0;
                rd_bank_r  <= wr_bank_r;
            end else begin
                case (rd_state_r)
                    ST_IDLE: begin
                        rd_cnt_r <= '0;
                    end
                    ST_READ: begin
                        if (rd_cnt_r == LAST) begin
                            rd_state_r <= ST_IDLE;
                            rd_cnt_r   <= '0;
                        end else begin
                            rd_cnt_r <= rd_cnt_r + LOGN'(1);
                        end
                    end
                    default: begin
                        rd_state_r <= ST_IDLE;
                        rd_cnt_r   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// -----------------------------------------------------------------------------
// tb_fft_bitrev_reorder
//
// Drives two instances (N=64/WIDTH=8 and N=16/WIDTH=12) from one shared
// stimulus stream and compares every cycle of both against a frame-level
// reference: complete frames are collected in arrays, and each completed
// frame schedules its natural-order bins at fixed future cycles.
// -----------------------------------------------------------------------------
module tb_fft_bitrev_reorder;

    localparam int MAXE = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_in;
    logic [11:0] in_re;
    logic [11:0] in_im;

    logic        o64_en;
    logic [7:0]  o64_re;
    logic [7:0]  o64_im;
    logic        o16_en;
    logic [11:0] o16_re;
    logic [11:0] o16_im;

    int n_total = 0;
    int n_bad   = 0;
    int edge_idx = 0;

    // Reference model state, index 0 = N64 instance, 1 = N16 instance.
    bit          exp_en  [2][MAXE];
    logic [11:0] exp_re  [2][MAXE];
    logic [11:0] exp_im  [2][MAXE];
    logic [11:0] buf_re  [2][64];
    logic [11:0] buf_im  [2][64];
    int          fill    [2];
    bit          cur_en  [2];
    logic [11:0] last_re [2];
    logic [11:0] last_im [2];

    always #5 clk = ~clk;

    fft_bitrev_reorder #(.N(64), .WIDTH(8)) u_dut64 (
        .clk        (clk),
        .rst        (rst),
        .enable_in  (enable_in),
        .in_re      (in_re[7:0]),
        .in_im      (in_im[7:0]),
        .enable_out (o64_en),
        .out_re     (o64_re),
        .out_im     (o64_im)
    );

    fft_bitrev_reorder #(.N(16), .WIDTH(12)) u_dut16 (
        .clk        (clk),
        .rst        (rst),
        .enable_in  (enable_in),
        .in_re      (in_re),
        .in_im      (in_im),
        .enable_out (o16_en),
        .out_re     (o16_re),
        .out_im     (o16_im)
    );

    function automatic int rev_idx(input int v, input int bits);
        int r;
        r = 0;
        for (int i = 0; i < bits; i++) begin
            r = (r << 1) | ((v >> i) & 1);
        end
        return r;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s edge=%0d got=%0h want=%0h", tag, edge_idx, obs, exp);
        end
    endtask

    // Advance the reference by one clock edge using the inputs just sampled.
    task automatic model_edge();
        int n;
        int bits;
        logic [11:0] mask;
        edge_idx++;
        for (int d = 0; d < 2; d++) begin
            n    = (d == 1) ? 16 : 64;
            bits = (d == 1) ? 4 : 6;
            mask = (d == 1) ? 12'hfff : 12'h0ff;
            if (rst) begin
                fill[d] = 0;
                for (int i = edge_idx; i < edge_idx + 80 && i < MAXE; i++) begin
                    exp_en[d][i] = 1'b0;
                end
                cur_en[d]  = 1'b0;
                last_re[d] = 12'h000;
                last_im[d] = 12'h000;
            end else begin
                if (enable_in) begin
                    buf_re[d][fill[d]] = in_re & mask;
                    buf_im[d][fill[d]] = in_im & mask;
                    fill[d]++;
                    if (fill[d] == n) begin
                        for (int j = 0; j < n; j++) begin
                            if (edge_idx + 1 + j < MAXE) begin
                                exp_en[d][edge_idx+1+j] = 1'b1;
                                exp_re[d][edge_idx+1+j] = buf_re[d][rev_idx(j, bits)];
                                exp_im[d][edge_idx+1+j] = buf_im[d][rev_idx(j, bits)];
                            end
                        end
                        fill[d] = 0;
                    end
                end else begin
                    fill[d] = 0;
                end
                cur_en[d] = exp_en[d][edge_idx];
                if (cur_en[d]) begin
                    last_re[d] = exp_re[d][edge_idx];
                    last_im[d] = exp_im[d][edge_idx];
                end
            end
        end
    endtask

    task automatic check_outputs();
        check_val("en64", 32'(o64_en), 32'(cur_en[0]));
        check_val("re64", 32'(o64_re), 32'(last_re[0]));
        check_val("im64", 32'(o64_im), 32'(last_im[0]));
        check_val("en16", 32'(o16_en), 32'(cur_en[1]));
        check_val("re16", 32'(o16_re), 32'(last_re[1]));
        check_val("im16", 32'(o16_im), 32'(last_im[1]));
    endtask

    // Inputs are applied at the falling edge and outputs checked there too.
    task automatic drive_cycle(input logic r, input logic en, input logic [11:0] re, input logic [11:0] im);
        rst       = r;
        enable_in = en;
        in_re     = re;
        in_im     = im;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive_cycle(1'b0, 1'b0, 12'($urandom), 12'($urandom));
        end
    endtask

    task automatic send_frame(input int n, input int base, input bit rand_im);
        logic [11:0] v;
        for (int k = 0; k < n; k++) begin
            v = 12'(base + k);
            drive_cycle(1'b0, 1'b1, v, rand_im ? 12'($urandom) : ~v);
        end
    endtask

    initial begin
        int burst;
        fill[0] = 0; fill[1] = 0;
        cur_en[0] = 1'b0; cur_en[1] = 1'b0;
        last_re[0] = 12'h000; last_re[1] = 12'h000;
        last_im[0] = 12'h000; last_im[1] = 12'h000;
        rst = 1'b1; enable_in = 1'b0; in_re = 12'h000; in_im = 12'h000;
        @(negedge clk);

        // Reset state.
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 12'h000, 12'h000);

        // Single frame, re=k, im=~k.
        send_frame(64, 0, 1'b0);
        idle(70);

        // Three back-to-back frames, re = 64*f + k.
        send_frame(192, 0, 1'b1);
        idle(70);

        // Partial frame of 20 dropped, then a full frame.
        send_frame(20, 12'h0a0, 1'b1);
        idle(1);
        send_frame(64, 12'h040, 1'b1);
        idle(70);

        // Reset while bin 10 is on the output and the next frame is part written.
        send_frame(64, 12'h100, 1'b1);
        send_frame(11, 12'h200, 1'b1);
        drive_cycle(1'b1, 1'b1, 12'h2ff, 12'h2ff);
        idle(5);
        send_frame(64, 12'h300, 1'b1);
        idle(70);

        // Short frames with 5-cycle gaps, re = 0x800 + k.
        for (int f = 0; f < 4; f++) begin
            send_frame(16, 12'h800, 1'b1);
            idle(5);
        end
        idle(30);

        // Reset held while enable_in is high for 70 cycles.
        for (int i = 0; i < 70; i++) drive_cycle(1'b1, 1'b1, 12'($urandom), 12'($urandom));
        idle(70);
        send_frame(64, 12'h020, 1'b1);
        idle(70);

        // Random burst lengths and gaps.
        for (int it = 0; it < 8; it++) begin
            burst = $urandom_range(1, 150);
            for (int k = 0; k < burst; k++) begin
                drive_cycle(1'b0, 1'b1, 12'($urandom), 12'($urandom));
            end
            idle($urandom_range(0, 6));
        end
        idle(70);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
